aes_inv_key_expander: RTL



---
 rtl/aes_inv_key_expander_if.sv | 31 +++
 rtl/aes_inv_key_expander.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_key_expander_if.sv
// Handshake bundle for the AES-128 inverse key expander.
//   start      : request to begin an expansion (honoured only when idle)
//   last_key   : round-10 key, captured on an accepted start
//   key_ready  : consumer accepts round_key while key_valid is high
//   round_key  : current round key, w0 in [127:96] ... w3 in [31:0]
//   round_idx  : round number of round_key (10 down to 0)
//   key_valid  : round_key/round_idx valid, held until key_ready
//   busy       : expansion in progress
//   done       : one-cycle pulse after the round-0 handshake
// The master modport is the requesting/consuming side and the slave
// modport is the expander itself.
interface aes_inv_key_expander_if;
  logic         start;
  logic [127:0] last_key;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         busy;
  logic         done;

  modport master (
    output start, last_key, key_ready,
    input  round_key, round_idx, key_valid, busy, done
  );

  modport slave (
    input  start, last_key, key_ready,
    output round_key, round_idx, key_valid, busy, done
  );
endinterface

// File: rtl/aes_inv_key_expander.sv
// Iterative AES-128 inverse key schedule. Loads the round-10 key and walks
// the expansion backwards, presenting round keys 10, 9, ..., 0 on a
// valid/ready handshake for the decryption datapath.
//
// Ports:
//   clk    : clock, all logic on the rising edge
//   reset  : synchronous, active-high
//   bus    : aes_inv_key_expander_if.slave (start/last_key/key_ready in,
//            round_key/round_idx/key_valid/busy/done out)
//
// Build option:
//   INVKEY_SBOX_REG_EN defined   -> SubWord result registered in sub_reg
//                                   (states IDLE/OUT/SUB/UPD, 3-cycle period)
//   INVKEY_SBOX_REG_EN undefined -> SubWord used combinationally in UPD
//                                   (states IDLE/OUT/UPD, 2-cycle period)
module aes_inv_key_expander (
  input  logic                         clk,
  input  logic                         reset,
  aes_inv_key_expander_if.slave        bus
);

`ifdef INVKEY_SBOX_REG_EN
  typedef enum logic [1:0] {IDLE, OUT, SUB, UPD} state_t;
`else
  typedef enum logic [1:0] {IDLE, OUT, UPD} state_t;
`endif

  state_t        state, next_state;
  logic [127:0]  key_reg;
  logic [3:0]    idx_reg;
  logic          done_reg;
  logic          load_c, upd_c, fin_c, valid_c;
  logic [31:0]   w0, w1, w2, w3;
  logic [31:0]   temp_c, sub_word_c, sub_use;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse (a^254, which maps 0 to 0)
  // followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Round constant of the key being undone (index before decrement).
  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [7:0] rc;
    case (i)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h000000};
  endfunction

  assign {w0, w1, w2, w3} = key_reg;
  // Previous-round w3 is w3^w2; the previous w0 needs SubWord(RotWord) of it.
  assign temp_c     = w3 ^ w2;
  assign sub_word_c = sub_word({temp_c[23:0], temp_c[31:24]});

`ifdef INVKEY_SBOX_REG_EN
  logic        sub_en_c;
  logic [31:0] sub_reg;

  always_ff @(posedge clk) begin
    if (reset)         sub_reg <= '0;
    else if (sub_en_c) sub_reg <= sub_word_c;
  end

  assign sub_use = sub_reg;
`else
  assign sub_use = sub_word_c;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state and control strobes
  always_comb begin
    next_state = state;
    load_c     = 1'b0;
    upd_c      = 1'b0;
    fin_c      = 1'b0;
    valid_c    = 1'b0;
`ifdef INVKEY_SBOX_REG_EN
    sub_en_c   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          load_c     = 1'b1;
          next_state = OUT;
        end
      end
      OUT: begin
        valid_c = 1'b1;
        if (bus.key_ready) begin
          if (idx_reg == 4'd0) begin
            fin_c      = 1'b1;
            next_state = IDLE;
          end else begin
`ifdef INVKEY_SBOX_REG_EN
            next_state = SUB;
`else
            next_state = UPD;
`endif
          end
        end
      end
`ifdef INVKEY_SBOX_REG_EN
      SUB: begin
        sub_en_c   = 1'b1;
        next_state = UPD;
      end
`endif
      UPD: begin
        upd_c      = 1'b1;
        next_state = OUT;
      end
      default: next_state = IDLE;
    endcase
  end

  // Key and round-index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      key_reg <= '0;
      idx_reg <= '0;
    end else if (load_c) begin
      key_reg <= bus.last_key;
      idx_reg <= 4'd10;
    end else if (upd_c) begin
      key_reg <= {w0 ^ sub_use ^ rcon(idx_reg), w1 ^ w0, w2 ^ w1, w3 ^ w2};
      idx_reg <= (idx_reg != 4'd0) ? idx_reg - 4'd1 : idx_reg;
    end
  end

  // Completion pulse follows the round-0 handshake
  always_ff @(posedge clk) begin
    if (reset) done_reg <= 1'b0;
    else       done_reg <= fin_c;
  end

  assign bus.round_key = key_reg;
  assign bus.round_idx = idx_reg;
  assign bus.key_valid = valid_c;
  assign bus.busy      = (state != IDLE);
  assign bus.done      = done_reg;

endmodule
